// File: rtl/act_sram_pkg.sv
// act_sram_pkg
//   Shared encodings for the activation SRAM write path: quadrant indices,
//   write layout mode, the write-controller FSM state type, and the number
//   of activations per channel in one SRAM word.
package act_sram_pkg;

   // Activations per channel per word (2x2 sub-positions).
   localparam int unsigned ACT_PER_ADDR = 4;

   // Quadrant indices of one post-processing output beat.
   localparam logic [1:0] QUAD_LU = 2'd0;
   localparam logic [1:0] QUAD_RU = 2'd1;
   localparam logic [1:0] QUAD_LD = 2'd2;
   localparam logic [1:0] QUAD_RD = 2'd3;

   typedef enum logic {
      MODE_CONV = 1'b0,
      MODE_UP   = 1'b1
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      PAD  = 1'b1
   } state_e;

endpackage

// File: rtl/act_slot_mask.sv
// act_slot_mask
//   Combinational active-low one-slot byte mask for one bank word.
//   Slot index = ch*ACT_PER_ADDR + sub; the mask bit of that slot is 0 and
//   every other bit is 1. Slots beyond the word leave the mask all ones.
// Ports:
//   ch   in  7            channel index
//   sub  in  2            sub-position within the channel
//   mask out CH_NUM*4     active-low slot mask
module act_slot_mask
   import act_sram_pkg::*;
#(
   parameter int unsigned CH_NUM = 24
) (
   input  logic [6:0]                       ch,
   input  logic [1:0]                       sub,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]   mask
);

   int unsigned slot;

   always_comb begin
      slot = 32'(ch) * ACT_PER_ADDR + 32'(sub);
      mask = '1;
      for (int unsigned i = 0; i < CH_NUM * ACT_PER_ADDR; i++) begin
         if (i == slot) mask[i] = 1'b0;
      end
   end

endmodule

// File: rtl/act_sram_write_ctl.sv
// act_sram_write_ctl
//   Write-side controller for the four-bank activation SRAM pair (set A/B).
//   Steers one 4-quadrant beat per cycle into the selected set in CONV or
//   2x upsample (UP) layout, and runs the zero-fill padding sequencer.
//   All SRAM-side outputs are registered (one cycle after acceptance).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pad_start/pad_sel     start zero-fill of set A (0) or B (1)
//   pad_done              pulse with the last pad word
//   in_valid/in_ready     beat handshake
//   in_mode/in_dst        CONV/UP layout, destination set
//   in_map_type, in_ch    CONV quadrant rotation, channel (UP: phase+channel)
//   in_addr0..3           per-bank addresses (UP: in_addr0 is the base)
//   in_lu/ru/ld/rd        quadrant activations
//   sram_wen_a/b          active-low per-bank write enables
//   sram_waddr0..3, sram_wdata0..3, sram_bytemask0..3  shared bank buses
// Configuration:
//   WR_ADDR_CHECK_EN      suppresses writes to addresses >= PAD_DEPTH and
//                         adds the sticky wr_addr_err output.
module act_sram_write_ctl
   import act_sram_pkg::*;
#(
   parameter int unsigned CH_NUM       = 24,
   parameter int unsigned BW_PER_ACT   = 16,
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned ROW_STRIDE   = 321,
   parameter int unsigned PAD_DEPTH    = 25921
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    pad_start,
   input  logic                                    pad_sel,
   output logic                                    pad_done,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic                                    in_mode,
   input  logic                                    in_dst,
   input  logic [1:0]                              in_map_type,
   input  logic [6:0]                              in_ch,
   input  logic [ADDR_W-1:0]                       in_addr0,
   input  logic [ADDR_W-1:0]                       in_addr1,
   input  logic [ADDR_W-1:0]                       in_addr2,
   input  logic [ADDR_W-1:0]                       in_addr3,
   input  logic [BW_PER_ACT-1:0]                   in_lu,
   input  logic [BW_PER_ACT-1:0]                   in_ru,
   input  logic [BW_PER_ACT-1:0]                   in_ld,
   input  logic [BW_PER_ACT-1:0]                   in_rd,
   output logic [3:0]                              sram_wen_a,
   output logic [3:0]                              sram_wen_b,
   output logic [ADDR_W-1:0]                       sram_waddr0,
   output logic [ADDR_W-1:0]                       sram_waddr1,
   output logic [ADDR_W-1:0]                       sram_waddr2,
   output logic [ADDR_W-1:0]                       sram_waddr3,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata0,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata1,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata2,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata3,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]          sram_bytemask0,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]          sram_bytemask1,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]          sram_bytemask2,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]          sram_bytemask3
`ifdef WR_ADDR_CHECK_EN
   ,
   output logic                                    wr_addr_err
`endif
);

   localparam int unsigned MW    = CH_NUM * ACT_PER_ADDR;
   localparam int unsigned DW    = MW * BW_PER_ACT;
   localparam int unsigned CNT_W = (PAD_DEPTH > 1) ? $clog2(PAD_DEPTH) : 1;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pad_sel_q, pad_sel_d;
   logic                   pad_done_q, pad_done_d;
   logic [3:0]             wen_a_q, wen_a_d, wen_b_q, wen_b_d;
   logic [ADDR_W-1:0]      waddr_q [4];
   logic [ADDR_W-1:0]      waddr_d [4];
   logic [DW-1:0]          wdata_q [4];
   logic [DW-1:0]          wdata_d [4];
   logic [MW-1:0]          mask_q  [4];
   logic [MW-1:0]          mask_d  [4];

   logic [ADDR_W-1:0]      in_addr   [4];
   logic [BW_PER_ACT-1:0]  quad      [4];
   logic [ADDR_W-1:0]      bank_addr [4];
   logic [BW_PER_ACT-1:0]  bank_act  [4];
   logic [6:0]             bank_ch   [4];
   logic [1:0]             bank_sub  [4];
   logic [MW-1:0]          bank_mask [4];
   logic [3:0]             beat_wen;

`ifdef WR_ADDR_CHECK_EN
   logic                   err_q, err_d;
   logic [3:0]             addr_bad;
`endif

   always_comb begin
      in_addr[0]    = in_addr0;
      in_addr[1]    = in_addr1;
      in_addr[2]    = in_addr2;
      in_addr[3]    = in_addr3;
      quad[QUAD_LU] = in_lu;
      quad[QUAD_RU] = in_ru;
      quad[QUAD_LD] = in_ld;
      quad[QUAD_RD] = in_rd;
   end

   // Per-bank steering. In UP layout the phase bits say which banks step
   // one column (+1) and/or one bank-row (+ROW_STRIDE) from the base: a bank
   // whose own index bit is 0 takes the offset selected by that phase bit.
   always_comb begin
      for (int unsigned b = 0; b < 4; b++) begin
         logic [1:0] bb;
         bb = 2'(b);
         if (mode_e'(in_mode) == MODE_UP) begin
            bank_act[b]  = quad[bb ^ in_ch[1:0]];
            bank_sub[b]  = ~in_ch[1:0];
            bank_ch[b]   = {2'b00, in_ch[6:2]};
            bank_addr[b] = in_addr[0]
                         + ((!bb[1] && in_ch[1]) ? ADDR_W'(ROW_STRIDE) : '0)
                         + ((!bb[0] && in_ch[0]) ? ADDR_W'(1) : '0);
         end else begin
            bank_act[b]  = quad[bb ^ in_map_type];
            bank_sub[b]  = ~(bb ^ in_map_type);
            bank_ch[b]   = in_ch;
            bank_addr[b] = in_addr[b];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_mask
      act_slot_mask #(.CH_NUM(CH_NUM)) u_slot_mask (
         .ch   (bank_ch[g]),
         .sub  (bank_sub[g]),
         .mask (bank_mask[g])
      );
   end

`ifdef WR_ADDR_CHECK_EN
   always_comb begin
      for (int unsigned b = 0; b < 4; b++) begin
         addr_bad[b] = {1'b0, bank_addr[b]} >= (ADDR_W + 1)'(PAD_DEPTH);
      end
      beat_wen = addr_bad;
   end
`else
   assign beat_wen = 4'b0000;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pad_sel_d  = pad_sel_q;
      pad_done_d = 1'b0;
      wen_a_d    = '1;
      wen_b_d    = '1;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      in_ready   = 1'b0;
`ifdef WR_ADDR_CHECK_EN
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            in_ready = !pad_start;
            if (pad_start) begin
               state_d   = PAD;
               cnt_d     = '0;
               pad_sel_d = pad_sel;
            end else if (in_valid) begin
               for (int unsigned b = 0; b < 4; b++) begin
                  waddr_d[b] = bank_addr[b];
                  wdata_d[b] = {MW{bank_act[b]}};
                  mask_d[b]  = bank_mask[b];
               end
               if (in_dst) wen_b_d = beat_wen;
               else        wen_a_d = beat_wen;
`ifdef WR_ADDR_CHECK_EN
               if (|addr_bad) err_d = 1'b1;
`endif
            end
         end
         PAD: begin
            for (int unsigned b = 0; b < 4; b++) begin
               waddr_d[b] = ADDR_W'(cnt_q);
               wdata_d[b] = '0;
               mask_d[b]  = '0;
            end
            if (pad_sel_q) wen_b_d = 4'b0000;
            else           wen_a_d = 4'b0000;
            if (cnt_q == CNT_W'(PAD_DEPTH - 1)) begin
               pad_done_d = 1'b1;
               state_d    = IDLE;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pad_sel_q  <= 1'b0;
         pad_done_q <= 1'b0;
         wen_a_q    <= '1;
         wen_b_q    <= '1;
         for (int unsigned b = 0; b < 4; b++) begin
            waddr_q[b] <= '0;
            wdata_q[b] <= '0;
            mask_q[b]  <= '1;
         end
`ifdef WR_ADDR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pad_sel_q  <= pad_sel_d;
         pad_done_q <= pad_done_d;
         wen_a_q    <= wen_a_d;
         wen_b_q    <= wen_b_d;
         for (int unsigned b = 0; b < 4; b++) begin
            waddr_q[b] <= waddr_d[b];
            wdata_q[b] <= wdata_d[b];
            mask_q[b]  <= mask_d[b];
         end
`ifdef WR_ADDR_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   assign pad_done       = pad_done_q;
   assign sram_wen_a     = wen_a_q;
   assign sram_wen_b     = wen_b_q;
   assign sram_waddr0    = waddr_q[0];
   assign sram_waddr1    = waddr_q[1];
   assign sram_waddr2    = waddr_q[2];
   assign sram_waddr3    = waddr_q[3];
   assign sram_wdata0    = wdata_q[0];
   assign sram_wdata1    = wdata_q[1];
   assign sram_wdata2    = wdata_q[2];
   assign sram_wdata3    = wdata_q[3];
   assign sram_bytemask0 = mask_q[0];
   assign sram_bytemask1 = mask_q[1];
   assign sram_bytemask2 = mask_q[2];
   assign sram_bytemask3 = mask_q[3];
`ifdef WR_ADDR_CHECK_EN
   assign wr_addr_err    = err_q;
`endif

endmodule

// File: tb/tb_act_sram_write_ctl.sv
// tb_act_sram_write_ctl
//   Scoreboard bench for act_sram_write_ctl with PAD_DEPTH = 8. Expected
//   SRAM writes are queued when stimulus is driven and compared whenever a
//   write enable goes low on either set.
module tb_act_sram_write_ctl;

   localparam int unsigned CH_NUM = 24;
   localparam int unsigned BW     = 16;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned RS     = 321;
   localparam int unsigned PDEP   = 8;
   localparam int unsigned MW     = CH_NUM * 4;
   localparam int unsigned DW     = MW * BW;

   typedef struct packed {
      logic [3:0]              wen_a;
      logic [3:0]              wen_b;
      logic                    pad_done;
      logic [3:0][ADDR_W-1:0]  addr;
      logic [3:0][BW-1:0]      act;
      logic [3:0][MW-1:0]      mask;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic pad_start, pad_sel, pad_done;
   logic in_valid, in_ready, in_mode, in_dst;
   logic [1:0] in_map_type;
   logic [6:0] in_ch;
   logic [ADDR_W-1:0] in_addr0, in_addr1, in_addr2, in_addr3;
   logic [BW-1:0] in_lu, in_ru, in_ld, in_rd;
   logic [3:0] sram_wen_a, sram_wen_b;
   logic [ADDR_W-1:0] sram_waddr0, sram_waddr1, sram_waddr2, sram_waddr3;
   logic [DW-1:0] sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3;
   logic [MW-1:0] sram_bytemask0, sram_bytemask1, sram_bytemask2, sram_bytemask3;
`ifdef WR_ADDR_CHECK_EN
   logic wr_addr_err;
   logic exp_err = 1'b0;
`endif

   logic [3:0][ADDR_W-1:0] obs_addr;
   logic [3:0][DW-1:0]     obs_data;
   logic [3:0][MW-1:0]     obs_mask;
   assign obs_addr = {sram_waddr3, sram_waddr2, sram_waddr1, sram_waddr0};
   assign obs_data = {sram_wdata3, sram_wdata2, sram_wdata1, sram_wdata0};
   assign obs_mask = {sram_bytemask3, sram_bytemask2, sram_bytemask1, sram_bytemask0};

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   act_sram_write_ctl #(
      .CH_NUM(CH_NUM), .BW_PER_ACT(BW), .ADDR_W(ADDR_W),
      .ROW_STRIDE(RS), .PAD_DEPTH(PDEP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pad_start(pad_start), .pad_sel(pad_sel), .pad_done(pad_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_dst(in_dst), .in_map_type(in_map_type), .in_ch(in_ch),
      .in_addr0(in_addr0), .in_addr1(in_addr1),
      .in_addr2(in_addr2), .in_addr3(in_addr3),
      .in_lu(in_lu), .in_ru(in_ru), .in_ld(in_ld), .in_rd(in_rd),
      .sram_wen_a(sram_wen_a), .sram_wen_b(sram_wen_b),
      .sram_waddr0(sram_waddr0), .sram_waddr1(sram_waddr1),
      .sram_waddr2(sram_waddr2), .sram_waddr3(sram_waddr3),
      .sram_wdata0(sram_wdata0), .sram_wdata1(sram_wdata1),
      .sram_wdata2(sram_wdata2), .sram_wdata3(sram_wdata3),
`ifdef WR_ADDR_CHECK_EN
      .wr_addr_err(wr_addr_err),
`endif
      .sram_bytemask0(sram_bytemask0), .sram_bytemask1(sram_bytemask1),
      .sram_bytemask2(sram_bytemask2), .sram_bytemask3(sram_bytemask3)
   );

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference layout model: addresses from an explicit per-phase table.
   function automatic exp_t model_beat(input logic mode, input logic dst,
                                       input logic [1:0] map, input logic [6:0] ch,
                                       input logic [3:0][ADDR_W-1:0] ad,
                                       input logic [3:0][BW-1:0] acts);
      exp_t e;
      logic [ADDR_W-1:0] base;
      logic [1:0] p, q, sub;
      logic [3:0] wen;
      int slot;
      base = ad[0];
      p    = ch[1:0];
      wen  = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         if (mode) begin
            q   = 2'(b) ^ p;
            sub = 2'd3 ^ p;
            slot = int'(ch[6:2]) * 4 + int'(sub);
            case (p)
               2'd0: e.addr[b] = base;
               2'd1: e.addr[b] = (b == 0 || b == 2) ? base + 16'd1 : base;
               2'd2: e.addr[b] = (b == 0 || b == 1) ? base + 16'(RS) : base;
               default: begin
                  case (b)
                     0: e.addr[b] = base + 16'(RS) + 16'd1;
                     1: e.addr[b] = base + 16'(RS);
                     2: e.addr[b] = base + 16'd1;
                     default: e.addr[b] = base;
                  endcase
               end
            endcase
         end else begin
            q   = 2'(b) ^ map;
            sub = 2'd3 ^ 2'(b) ^ map;
            slot = int'(ch) * 4 + int'(sub);
            e.addr[b] = ad[b];
         end
         e.act[b]  = acts[q];
         e.mask[b] = '1;
         if (slot < int'(MW)) e.mask[b][slot] = 1'b0;
`ifdef WR_ADDR_CHECK_EN
         if (int'(e.addr[b]) >= int'(PDEP)) wen[b] = 1'b1;
`endif
      end
      e.wen_a    = dst ? 4'hF : wen;
      e.wen_b    = dst ? wen : 4'hF;
      e.pad_done = 1'b0;
      return e;
   endfunction

   // Drive one beat for one cycle (entered just after a rising edge).
   task automatic drive_beat(input logic mode, input logic dst, input logic [1:0] map,
                             input logic [6:0] ch, input logic [3:0][ADDR_W-1:0] ad,
                             input logic [3:0][BW-1:0] acts);
      exp_t e;
      in_valid = 1'b1; in_mode = mode; in_dst = dst; in_map_type = map; in_ch = ch;
      {in_addr3, in_addr2, in_addr1, in_addr0} = ad;
      {in_rd, in_ld, in_ru, in_lu} = acts;
      #1 chk_eq("beat_in_ready", 128'(in_ready), 128'(1));
      e = model_beat(mode, dst, map, ch, ad, acts);
      if (e.wen_a != 4'hF || e.wen_b != 4'hF) exp_q.push_back(e);
`ifdef WR_ADDR_CHECK_EN
      if ((dst ? e.wen_b : e.wen_a) != 4'h0) exp_err = 1'b1;
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_pad(input logic sel);
      exp_t e;
      for (int i = 0; i < int'(PDEP); i++) begin
         e.wen_a    = sel ? 4'hF : 4'h0;
         e.wen_b    = sel ? 4'h0 : 4'hF;
         e.pad_done = (i == int'(PDEP) - 1);
         for (int b = 0; b < 4; b++) begin
            e.addr[b] = 16'(i);
            e.act[b]  = '0;
            e.mask[b] = '0;
         end
         exp_q.push_back(e);
      end
   endtask

   // Full pad run; with_beat also presents a beat in the start cycle.
   task automatic run_pad(input logic sel, input logic with_beat);
      push_pad(sel);
      pad_start = 1'b1; pad_sel = sel; in_valid = with_beat;
      in_mode = 1'b0; in_dst = 1'b0; in_map_type = 2'd0; in_ch = 7'd1;
      {in_addr3, in_addr2, in_addr1, in_addr0} = {16'd3, 16'd3, 16'd3, 16'd3};
      @(negedge clk) chk_eq("pad_start_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      pad_start = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < int'(PDEP); i++) begin
         @(negedge clk) chk_eq("pad_busy_ready", 128'(in_ready), 128'(0));
         @(posedge clk); #1;
      end
      @(negedge clk) chk_eq("pad_end_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (sram_wen_a != 4'hF || sram_wen_b != 4'hF) begin
            if (exp_q.size() == 0) begin
               chk_eq("unexpected_write", 128'({sram_wen_b, sram_wen_a}), 128'(8'hFF));
            end else begin
               e = exp_q.pop_front();
               chk_eq("wen_a", 128'(sram_wen_a), 128'(e.wen_a));
               chk_eq("wen_b", 128'(sram_wen_b), 128'(e.wen_b));
               chk_eq("pad_done", 128'(pad_done), 128'(e.pad_done));
               for (int b = 0; b < 4; b++) begin
                  chk_eq($sformatf("addr%0d", b), 128'(obs_addr[b]), 128'(e.addr[b]));
                  chk_eq($sformatf("data%0d_slot0", b), 128'(obs_data[b][BW-1:0]), 128'(e.act[b]));
                  chk_eq($sformatf("data%0d_repl", b),
                         128'(obs_data[b] == {MW{e.act[b]}}), 128'(1));
                  chk_eq($sformatf("mask%0d", b), 128'(obs_mask[b]), 128'(e.mask[b]));
               end
            end
         end else if (pad_done) begin
            chk_eq("stray_pad_done", 128'(pad_done), 128'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0][ADDR_W-1:0] ad;
      logic [3:0][BW-1:0] acts;
      rst_n = 1'b0; pad_start = 1'b0; pad_sel = 1'b0; in_valid = 1'b0;
      in_mode = 1'b0; in_dst = 1'b0; in_map_type = 2'd0; in_ch = 7'd0;
      {in_addr3, in_addr2, in_addr1, in_addr0} = '0;
      {in_rd, in_ld, in_ru, in_lu} = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk_eq("rst_wen_a", 128'(sram_wen_a), 128'(4'hF));
      chk_eq("rst_wen_b", 128'(sram_wen_b), 128'(4'hF));
      chk_eq("rst_mask0", 128'(sram_bytemask0), {32'h0, {MW{1'b1}}});
      chk_eq("rst_mask3", 128'(sram_bytemask3), {32'h0, {MW{1'b1}}});
      chk_eq("rst_addr2", 128'(sram_waddr2), 128'(0));
      chk_eq("rst_data1_zero", 128'(sram_wdata1 == '0), 128'(1));
      chk_eq("rst_pad_done", 128'(pad_done), 128'(0));
      chk_eq("rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;

      // CONV beat: map 2, ch 5, addr 10..13, acts 1..4, dst B.
      drive_beat(1'b0, 1'b1, 2'd2, 7'd5, {16'd13, 16'd12, 16'd11, 16'd10},
                 {16'd4, 16'd3, 16'd2, 16'd1});
      // UP beat: in_ch 7 (phase 3, ch 1), base 100, dst A.
      drive_beat(1'b1, 1'b0, 2'd0, 7'd7, {16'd0, 16'd0, 16'd0, 16'd100},
                 {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA});
      @(negedge clk);
      @(negedge clk);
      chk_eq("hold_wen_a", 128'(sram_wen_a), 128'(4'hF));
      chk_eq("hold_addr0", 128'(sram_waddr0), 128'(422));
      @(posedge clk); #1;

      // UP beat at the top of the address space: sums wrap.
      drive_beat(1'b1, 1'b1, 2'd0, 7'd3, {16'd0, 16'd0, 16'd0, 16'hFFFF},
                 {16'h0004, 16'h0003, 16'h0002, 16'h0001});

      // Back-to-back random beats, mostly in range for the check build.
      for (int i = 0; i < 24; i++) begin
         for (int b = 0; b < 4; b++) begin
            ad[b]   = 16'($urandom_range(0, 11));
            acts[b] = 16'($urandom);
         end
         drive_beat(1'($urandom), 1'($urandom), 2'($urandom), 7'($urandom), ad, acts);
      end
      repeat (2) @(posedge clk); #1;

      run_pad(1'b0, 1'b0);
      run_pad(1'b1, 1'b1);

      // Reset in the middle of a pad fill.
      push_pad(1'b0);
      pad_start = 1'b1; pad_sel = 1'b0;
      @(posedge clk); #1 pad_start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("midpad_rst_wen_a", 128'(sram_wen_a), 128'(4'hF));
      chk_eq("midpad_rst_pad_done", 128'(pad_done), 128'(0));
      chk_eq("midpad_rst_addr0", 128'(sram_waddr0), 128'(0));
      exp_q.delete();
`ifdef WR_ADDR_CHECK_EN
      exp_err = 1'b0;
      chk_eq("rst_wr_addr_err", 128'(wr_addr_err), 128'(0));
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (PDEP + 4) @(posedge clk);
      #1 chk_eq("post_rst_in_ready", 128'(in_ready), 128'(1));

`ifdef WR_ADDR_CHECK_EN
      // UP phase 1 at base PAD_DEPTH-1: banks 0 and 2 land at PAD_DEPTH.
      drive_beat(1'b1, 1'b0, 2'd0, 7'd9, {16'd0, 16'd0, 16'd0, 16'(PDEP - 1)},
                 {16'd8, 16'd7, 16'd6, 16'd5});
      @(negedge clk);
      chk_eq("chk_wen_a", 128'(sram_wen_a), 128'(4'b0101));
      chk_eq("wr_addr_err", 128'(wr_addr_err), 128'(exp_err));
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1 chk_eq("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
